// File: rtl/arf_rat_pkg.sv
// arf_rat_pkg: global definitions for the architectural register file / rename table.
// Defines the default sizes ARF_N_ENTRIES, ARF_ID_WIDTH, ROB_ID_WIDTH and REG_WIDTH.
// Also defines arf_entry_t, which holds one register's state: data, busy and tag.
`ifndef ARF_RAT_GLOBAL_DEFS
`define ARF_RAT_GLOBAL_DEFS
`define ARF_N_ENTRIES 32
`define ARF_ID_WIDTH 5
`define ROB_ID_WIDTH 6
`define REG_WIDTH 32
`endif

package arf_rat_pkg;
    typedef struct packed {
        logic [`REG_WIDTH-1:0]    data;
        logic                     busy;
        logic [`ROB_ID_WIDTH-1:0] tag;
    } arf_entry_t;
    localparam int ARF_ENTRY_W = $bits(arf_entry_t);
endpackage

// File: rtl/arf_rat_entry.sv
// rat_entry: state and next-state logic for one architectural register (data, busy, rename tag).
// Ports:
//   clk, rst_aL                             - clock, asynchronous active-low reset
//   i_rename, i_rob_id                      - dispatch renames this register to i_rob_id
//   i_retire, i_retire_rob_id, i_retire_data - retirement of this register: its tag and its value
//   i_flush                                 - drop the speculative mapping
//   o_data, o_busy, o_tag                   - current state
module rat_entry
    import arf_rat_pkg::*;
#(
    parameter int REG_WIDTH    = `REG_WIDTH,
    parameter int ROB_ID_WIDTH = `ROB_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_aL,
    input  logic                    i_rename,
    input  logic [ROB_ID_WIDTH-1:0] i_rob_id,
    input  logic                    i_retire,
    input  logic [ROB_ID_WIDTH-1:0] i_retire_rob_id,
    input  logic [REG_WIDTH-1:0]    i_retire_data,
    input  logic                    i_flush,
    output logic [REG_WIDTH-1:0]    o_data,
    output logic                    o_busy,
    output logic [ROB_ID_WIDTH-1:0] o_tag
);
    logic [REG_WIDTH-1:0]    r_data;
    logic                    r_busy;
    logic [ROB_ID_WIDTH-1:0] r_tag;
    logic                    w_rename;
    logic                    w_clear;

    assign w_rename = i_rename && !i_flush;
    // Only the youngest producer may clear busy; an older retire just updates data.
    assign w_clear  = i_retire && (r_tag == i_retire_rob_id);

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_data <= '0;
            r_busy <= 1'b0;
            r_tag  <= '0;
        end else begin
            if (i_retire) r_data <= i_retire_data;
            r_busy <= i_flush ? 1'b0 : w_rename ? 1'b1 : w_clear ? 1'b0 : r_busy;
            if (w_rename) r_tag <= i_rob_id;
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;
    assign o_tag  = r_tag;
endmodule

// File: rtl/arf_rat_mux.sv
// mux_: shared N:1 word multiplexer used by the register lookup ports.
// Ports:
//   i_in  - N candidate words
//   i_sel - index of the word to select
//   o_out - selected word; zero when i_sel is out of range
module mux_ #(
    parameter int N  = 2,
    parameter int W  = 1,
    parameter int SW = 1
) (
    input  logic [N-1:0][W-1:0] i_in,
    input  logic [SW-1:0]       i_sel,
    output logic [W-1:0]        o_out
);
    assign o_out = (32'(i_sel) < N) ? i_in[i_sel] : '0;
endmodule

// File: rtl/arf_rat.sv
// arf_rat: architectural register file combined with the register alias table.
// Register 0 is hardwired to zero and is never busy.
// Ports:
//   clk, rst_aL                                  - clock, asynchronous active-low reset
//   dispatch_valid, dispatch_dst_valid,
//   dispatch_dst_arf_id, dispatch_rob_id         - rename of the destination at dispatch
//   src1/src2_arf_id                             - source lookups
//   src1/src2_busy, _rob_id, _data               - lookup results, including the retire bypass
//   retire_valid, retire_arf_id,
//   retire_rob_id, retire_reg_data               - ROB head retirement
//   flush                                        - discard all speculative mappings
module arf_rat
    import arf_rat_pkg::*;
#(
    parameter int N_REGS       = `ARF_N_ENTRIES,
    parameter int REG_WIDTH    = `REG_WIDTH,
    parameter int ROB_ID_WIDTH = `ROB_ID_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic                     dispatch_valid,
    input  logic                     dispatch_dst_valid,
    input  logic [`ARF_ID_WIDTH-1:0] dispatch_dst_arf_id,
    input  logic [ROB_ID_WIDTH-1:0]  dispatch_rob_id,
    input  logic [`ARF_ID_WIDTH-1:0] src1_arf_id,
    input  logic [`ARF_ID_WIDTH-1:0] src2_arf_id,
    output logic                     src1_busy,
    output logic                     src2_busy,
    output logic [ROB_ID_WIDTH-1:0]  src1_rob_id,
    output logic [ROB_ID_WIDTH-1:0]  src2_rob_id,
    output logic [REG_WIDTH-1:0]     src1_data,
    output logic [REG_WIDTH-1:0]     src2_data,
    input  logic                     retire_valid,
    input  logic [`ARF_ID_WIDTH-1:0] retire_arf_id,
    input  logic [ROB_ID_WIDTH-1:0]  retire_rob_id,
    input  logic [REG_WIDTH-1:0]     retire_reg_data,
    input  logic                     flush
);
    localparam int AW = `ARF_ID_WIDTH;
    // Entry word layout: {data, busy, tag}, matching arf_entry_t.
    localparam int EW = REG_WIDTH + 1 + ROB_ID_WIDTH;

    logic [N_REGS-1:0][EW-1:0] w_ent;
    logic [EW-1:0]             w_look1;
    logic [EW-1:0]             w_look2;
    logic                      w_hit1;
    logic                      w_hit2;
    logic                      w_dispatch;

    assign w_dispatch = dispatch_valid && dispatch_dst_valid;

    for (genvar i = 0; i < N_REGS; i++) begin : g_ent
        if (i == 0) begin : g_zero
            assign w_ent[i] = '0;
        end else begin : g_reg
            rat_entry #(
                .REG_WIDTH   (REG_WIDTH),
                .ROB_ID_WIDTH(ROB_ID_WIDTH)
            ) u_entry (
                .clk            (clk),
                .rst_aL         (rst_aL),
                .i_rename       (w_dispatch && dispatch_dst_arf_id == AW'(i)),
                .i_rob_id       (dispatch_rob_id),
                .i_retire       (retire_valid && retire_arf_id == AW'(i)),
                .i_retire_rob_id(retire_rob_id),
                .i_retire_data  (retire_reg_data),
                .i_flush        (flush),
                .o_data         (w_ent[i][EW-1 -: REG_WIDTH]),
                .o_busy         (w_ent[i][ROB_ID_WIDTH]),
                .o_tag          (w_ent[i][ROB_ID_WIDTH-1:0])
            );
        end
    end

    mux_ #(.N(N_REGS), .W(EW), .SW(AW)) u_mux1 (.i_in(w_ent), .i_sel(src1_arf_id), .o_out(w_look1));
    mux_ #(.N(N_REGS), .W(EW), .SW(AW)) u_mux2 (.i_in(w_ent), .i_sel(src2_arf_id), .o_out(w_look2));

    // Bypass: the producer retiring this cycle makes the source ready with the retiring value.
    assign w_hit1 = retire_valid && retire_arf_id == src1_arf_id && w_look1[ROB_ID_WIDTH]
                    && w_look1[ROB_ID_WIDTH-1:0] == retire_rob_id;
    assign w_hit2 = retire_valid && retire_arf_id == src2_arf_id && w_look2[ROB_ID_WIDTH]
                    && w_look2[ROB_ID_WIDTH-1:0] == retire_rob_id;

    assign src1_busy   = w_look1[ROB_ID_WIDTH] && !w_hit1;
    assign src2_busy   = w_look2[ROB_ID_WIDTH] && !w_hit2;
    assign src1_rob_id = w_look1[ROB_ID_WIDTH-1:0];
    assign src2_rob_id = w_look2[ROB_ID_WIDTH-1:0];
    assign src1_data   = w_hit1 ? retire_reg_data : w_look1[EW-1 -: REG_WIDTH];
    assign src2_data   = w_hit2 ? retire_reg_data : w_look2[EW-1 -: REG_WIDTH];
endmodule

// File: doc/arf_rat.md
ARF_RAT -- requirements
Module: arf_rat

Interface
REQ-001 SHALL take parameter N_REGS, default `ARF_N_ENTRIES (32): architectural register count.
REQ-002 SHALL take parameter REG_WIDTH, default `REG_WIDTH: data width.
REQ-003 SHALL take parameter ROB_ID_WIDTH, default `ROB_ID_WIDTH: rename tag width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_aL  input  1  reset, asynchronous, active-low.
REQ-006 dispatch_valid  input  1  dispatch handshake fired this cycle (ROB/IIQ/LSQ all ready).
REQ-007 dispatch_dst_valid  input  1  dispatching instruction writes a destination.
REQ-008 dispatch_dst_arf_id  input  `ARF_ID_WIDTH  destination architectural register.
REQ-009 dispatch_rob_id  input  ROB_ID_WIDTH  ROB entry allocated to the dispatching instruction.
REQ-010 src1_arf_id, src2_arf_id  input  `ARF_ID_WIDTH each  source register lookups.
REQ-011 src1_busy, src2_busy  output  1 each  source renamed to an uncommitted ROB entry.
REQ-012 src1_rob_id, src2_rob_id  output  ROB_ID_WIDTH each  producer tag, meaningful only when busy.
REQ-013 src1_data, src2_data  output  REG_WIDTH each  committed value, meaningful only when not busy.
REQ-014 retire_valid  input  1  ROB head retiring with a destination; no backpressure, always accepted.
REQ-015 retire_arf_id / retire_rob_id / retire_reg_data  input  `ARF_ID_WIDTH / ROB_ID_WIDTH / REG_WIDTH  retiring destination, its tag, its value.
REQ-016 flush  input  1  pipeline flush on mispredict; discards all speculative mappings.

Function
REQ-017 Per register state SHALL be: data (REG_WIDTH), busy (1), tag (ROB_ID_WIDTH).
REQ-018 Source lookup SHALL be combinational from current state with retire bypass: if retire_valid, retire_arf_id==src id, busy set and tag==retire_rob_id, output busy=0, data=retire_reg_data.
REQ-019 Source lookups SHALL reflect mappings before the same cycle's dispatch rename (instruction reads its own sources' old mappings, e.g. add x5,x5,x1).
REQ-020 Register 0 SHALL read busy=0, data=0 always; writes and renames to register 0 SHALL be ignored.
REQ-021 On dispatch_valid & dispatch_dst_valid, next edge SHALL set busy=1, tag=dispatch_rob_id for dispatch_dst_arf_id.
REQ-022 On retire_valid, next edge SHALL write retire_reg_data into data[retire_arf_id] unconditionally.
REQ-023 Retire SHALL clear busy only if tag==retire_rob_id (no younger rename outstanding); otherwise busy/tag unchanged.
REQ-024 Retire and dispatch to the same register in one cycle: data written, busy=1, tag=dispatch_rob_id (dispatch wins).
REQ-025 flush SHALL clear all busy bits at next edge; a dispatch in the flush cycle SHALL NOT rename; a retire in the flush cycle SHALL still write data.
REQ-026 Latency: rename/retire/flush effects visible to lookups the cycle after the edge; retire data also visible same cycle via REQ-018 bypass.
REQ-027 Tags SHALL be compared at full ROB_ID_WIDTH; no wrap-around handling beyond equality.

Reset
REQ-028 rst_aL low SHALL asynchronously clear all data to 0 and all busy bits to 0; tags SHALL be 0.
REQ-029 After reset all lookup outputs SHALL be busy=0, rob_id=0, data=0; reset mid-operation discards all renames immediately.

Structure
REQ-030 `ARF_N_ENTRIES, `ARF_ID_WIDTH, `ROB_ID_WIDTH, `REG_WIDTH and an arf_entry_t struct (data, busy, tag) SHALL live in global_defs.svh.
REQ-031 One sub-module rat_entry SHALL hold one register's state and next-state logic; arf_rat instantiates N_REGS-1 of them plus constant register 0.
REQ-032 Lookup ports SHALL use the shared mux_ cell.

Verification
REQ-033 Reset, read x7 -> busy=0, data=0; dispatch x7 tag 3 -> next cycle busy=1, rob_id=3.
REQ-034 x7 tag 3; retire x7 tag 3 data 0xDEAD with lookup x7 same cycle -> busy=0, data=0xDEAD same cycle; stays after edge.
REQ-035 x7 tag 3, then rename x7 tag 9; retire tag 3 data 0x11 -> data=0x11 stored, busy=1, rob_id=9 persists.
REQ-036 Same cycle retire x4 tag 2 data 0x5 and dispatch x4 tag 6 -> next cycle busy=1, rob_id=6; later retire tag 6 data 0x8 -> busy=0, data=0x8.
REQ-037 x3,x8 busy; flush with dispatch x9 tag 1 -> next cycle all busy=0, x9 not renamed; dispatch/retire to x0 -> x0 reads 0, busy=0.
REQ-038 rst_aL asserted between clock edges with x3 busy -> outputs clear immediately without clock edge.
